// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: loads a pattern into a scan chain, runs functional capture
// clocks, unloads the chain response and compares it against an expected value.
module scan_test_ctrl #(
  parameter int CHAIN_LEN      = 4,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out_i,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);

  localparam int MAX_LEN = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, UNLOAD} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] captured_q, captured_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pat_q      <= '0;
      exp_q      <= '0;
      captured_q <= '0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      exp_q      <= exp_d;
      captured_q <= captured_d;
      scan_en_q  <= scan_en_d;
      scan_in_q  <= scan_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  // pat_q is a shift copy of the pattern: its bit N-2 is always the next bit to present.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    captured_d = captured_q;
    scan_en_d  = scan_en_q;
    scan_in_d  = scan_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d      = pattern_in;
          exp_d      = expected;
          pass_d     = 1'b0;
          captured_d = '0;
          busy_d     = 1'b1;
          scan_en_d  = 1'b1;
          scan_in_d  = pattern_in[CHAIN_LEN-1];
          cnt_d      = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        pat_d = pat_q << 1;
        if (cnt_q == SHIFT_LAST) begin
          scan_en_d = 1'b0;
          scan_in_d = 1'b0;
          cnt_d     = '0;
          state_d   = CAPTURE;
        end else begin
          scan_in_d = pat_q[CHAIN_LEN-2];
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      CAPTURE: begin
        if (cnt_q == CAP_LAST) begin
          scan_en_d = 1'b1;
          scan_in_d = 1'b0;
          cnt_d     = '0;
          state_d   = UNLOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      UNLOAD: begin
        // Chain MSB leaves first, so it ends up in captured[N-1] after N shifts.
        captured_d = {captured_q[CHAIN_LEN-2:0], scan_out_i};
        if (cnt_q == SHIFT_LAST) begin
          scan_en_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (captured_d == exp_q);
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan_en  = scan_en_q;
  assign scan_in  = scan_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign captured = captured_q;

endmodule

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
- Scan test sequencer directly upstream of four_bit_counter_scan. It drives the counter's scan_en and scan_in, and consumes its scan_out.
- For each start request it runs one complete scan test: load a pattern, run functional capture clock(s), unload the chain response.
- It compares the unloaded response against an expected value and reports pass/fail.
- Provides the DFT load/capture/unload sequence that the counter block itself does not generate.

Parameters:
CHAIN_LEN, 4, number of flops in the scan chain; minimum 2.
CAPTURE_CYCLES, 1, functional clocks with scan_en=0 between load and unload; minimum 1.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request one scan test; sampled only in IDLE.
pattern_in  input  CHAIN_LEN  stimulus to load; latched at start.
expected  input  CHAIN_LEN  expected chain contents after capture; latched at start.
scan_out_i  input  1  from chain scan_out (last flop, chain bit CHAIN_LEN-1).
scan_en  output  1  to chain scan_en.
scan_in  output  1  to chain scan_in (enters chain bit 0, shifts toward MSB).
busy  output  1  test in progress.
done  output  1  one-cycle pulse when result is valid.
pass  output  1  captured==expected_latched; valid from done, held until next accepted start.
captured  output  CHAIN_LEN  unloaded chain contents, bit i = chain bit i.

Behaviour:
- All outputs are registered.
- rst=0 forces, asynchronously: state IDLE, scan_en=0, scan_in=0, busy=0, done=0, pass=0, captured=0, internal counters=0.
- Reset mid-test aborts immediately with no partial result.
- States: IDLE, LOAD, CAPTURE, UNLOAD. The counter width is clog2(max(CHAIN_LEN, CAPTURE_CYCLES)) plus 1.
- Timeline is relative to edge E0, where start=1 is sampled in IDLE. N=CHAIN_LEN, C=CAPTURE_CYCLES.
- E0:
  - latch pattern_in and expected;
  - clear pass and captured; clear done;
  - set busy=1, scan_en=1, scan_in=pattern[N-1]; go to LOAD.
- LOAD, edges E1..EN:
  - the chain shifts in pattern[N-1] down to pattern[0], MSB first;
  - after Ek (k<N), scan_in=pattern[N-1-k];
  - after EN, scan_en=0 and scan_in=0; go to CAPTURE.
  - Net effect: the chain holds exactly pattern_in.
- CAPTURE, edges E(N+1)..E(N+C):
  - the chain runs functionally;
  - after E(N+C), scan_en=1, scan_in=0; go to UNLOAD.
- UNLOAD, edges E(N+C+1)..E(2N+C):
  - on each edge, captured <= {captured[N-2:0], scan_out_i}, sampling the pre-shift chain MSB;
  - the chain shifts in zeros;
  - after E(2N+C), captured holds the post-capture chain contents.
- After E(2N+C):
  - scan_en=0, busy=0, done=1 for exactly one cycle;
  - pass=(captured==expected_latched);
  - go to IDLE.
- Total test length: 2N+C edges after E0; done is high during the cycle after E(2N+C).
- start while busy=1 is ignored; no queueing.
- start=1 sampled in the done cycle is accepted as a new E0: done clears, busy goes back to 1 at the next edge.
- scan_in is 0 whenever scan_en=0, and whenever in UNLOAD.
- pattern_in and expected may change freely after E0 without affecting the running test.
- Counter wrap in the chain under test is the chain's concern; the controller compares raw bits only.

Test Plan:
1. Reset:
   - hold rst=0 for 2 cycles, toggling start;
   - required: scan_en=0, scan_in=0, busy=0, done=0, pass=0, captured=0000;
   - release rst=1: no activity until start.
2. Nominal, with a four_bit_counter_scan instance (N=4, C=1), pattern 1010, expected 1011:
   - scan_in=1,0,1,0 on E1..E4 with scan_en=1;
   - scan_en=0 for exactly one cycle (the counter captures, goes 1010 to 1011);
   - done pulses after E9 with captured=1011, pass=1.
3. Wrap and mismatch:
   - pattern 1111, expected 0000: captured=0000, pass=1;
   - repeat with expected 1111: captured=0000, pass=0, done still pulses after E9.
4. Start handling:
   - hold start=1 throughout a test: the second start is ignored while busy;
   - start=1 in the done cycle begins a new test: busy re-asserts next edge, and scan_in on E1 is the new pattern MSB.
5. Reset mid-LOAD:
   - drive rst=0 after E2 of a test;
   - scan_en and busy drop to 0 immediately, no done pulse;
   - after release, a fresh test with pattern 0011, expected 0100 gives pass=1.
6. CAPTURE_CYCLES=2 with the counter, pattern 0110, expected 1000:
   - scan_en is low for exactly 2 cycles;
   - captured=1000, pass=1, done after E10.
